// File: rtl/proc_pkg.sv
// Shared definitions for the processor run-control slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proc_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;

  typedef enum logic [1:0] {
    RUN_IDLE   = 2'd0,
    RUN_ACTIVE = 2'd1,
    RUN_DONE   = 2'd2
  } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over inc.
// Latency: count reflects clear/inc one edge later.
// Backpressure: none; inc is ignored once the counter is saturated.
module sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         a_reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones, clear on demand.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: gates architectural updates, counts executed cycles, detects halt/loop/timeout.
// Latency: o_exec_en combinational; o_done/o_timeout/o_cycle update on the edge after the cause.
// Backpressure: i_step_mode/i_step throttle execution; a stop blocks o_exec_en in the same cycle.
module proc_run_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_DEFAULT,
  parameter int unsigned     CYCLE_W     = 4,
  parameter int unsigned     MAX_CYCLES  = 15,
  parameter logic [XLEN-1:0] HALT_INSN   = XLEN'(INSN_EBREAK),
  parameter bit              LOOP_DETECT = 1'b1
) (
  input  logic               clk,
  input  logic               a_reset_n,
  input  logic               i_start,
  input  logic               i_step_mode,
  input  logic               i_step,
  input  logic [XLEN-1:0]    i_pc,
  input  logic [XLEN-1:0]    i_insn,
  output logic               o_exec_en,
  output logic               o_done,
  output logic               o_timeout,
  output logic [CYCLE_W-1:0] o_cycle
);

  localparam logic [CYCLE_W-1:0] MAX_CNT = CYCLE_W'(MAX_CYCLES);
  localparam bit                 TMO_EN  = (MAX_CYCLES != 0);

  run_state_t      state;
  logic [XLEN-1:0] prev_pc;
  logic            prev_valid;

  logic is_active;
  logic wants;
  logic loop_hit;
  logic halt_now;
  logic tmo_now;
  logic restart;

  assign is_active = (state == RUN_ACTIVE);
  // A mode change applies immediately: free-run always wants, step mode only on a pulse.
  assign wants     = !i_step_mode || i_step;
  // prev_pc only moves on executed cycles, so idle step gaps never look like a jump-to-self.
  assign loop_hit  = LOOP_DETECT && prev_valid && (i_pc == prev_pc);
  assign halt_now  = (i_insn == HALT_INSN) || loop_hit;
  assign tmo_now   = TMO_EN && (o_cycle == MAX_CNT);
  assign o_exec_en = is_active && wants && !halt_now && !tmo_now;
  // Start is only honoured outside a run; clearing the counter here keeps it aligned with the FSM.
  assign restart   = i_start && !is_active;

  sat_counter #(
    .W (CYCLE_W)
  ) u_cycle_cnt (
    .clk       (clk),
    .a_reset_n (a_reset_n),
    .clear     (restart),
    .inc       (o_exec_en),
    .count     (o_cycle)
  );

  // Run FSM with registered completion flags and loop history; halt outranks timeout.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state      <= RUN_IDLE;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
    end else begin
      case (state)
        RUN_IDLE, RUN_DONE: begin
          if (i_start) begin
            state      <= RUN_ACTIVE;
            o_done     <= 1'b0;
            o_timeout  <= 1'b0;
            prev_pc    <= '0;
            prev_valid <= 1'b0;
          end
        end
        RUN_ACTIVE: begin
          if (o_exec_en) begin
            prev_pc    <= i_pc;
            prev_valid <= 1'b1;
          end else if (wants && halt_now) begin
            state     <= RUN_DONE;
            o_done    <= 1'b1;
            o_timeout <= 1'b0;
          end else if (wants && tmo_now) begin
            state     <= RUN_DONE;
            o_done    <= 1'b1;
            o_timeout <= 1'b1;
          end
        end
        default: state <= RUN_IDLE;
      endcase
    end
  end

endmodule

// File: doc/proc_run_ctrl.md
# proc_run_ctrl

Parametrised run controller for the RISC-V processor top. It gates architectural state updates (PC, register file, memory writes) through a single execute enable and counts executed cycles. It also detects program completion by halt instruction, jump-to-self loop or cycle timeout, and supports single-step debug. It generalises the fixed 4-bit cycle/done reporting of the current top into a configurable, restartable block that the top instantiates between fetch and PC update.

## Interface
- `XLEN`, 32: PC and instruction width.
- `CYCLE_W`, 4: width of the executed-cycle counter `o_cycle`.
- `MAX_CYCLES`, 15: timeout limit in executed cycles. 0 disables timeout. Must be at most 2^CYCLE_W−1.
- `HALT_INSN`, 32'h0010_0073: instruction encoding that halts the run (ebreak).
- `LOOP_DETECT`, 1: 1 enables jump-to-self halt detection.
- `clk`  in  1  clock, rising edge.
- `a_reset_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  start/restart pulse; honoured in IDLE and DONE only.
- `i_step_mode`  in  1  1 = single-step, 0 = free-run; sampled every cycle.
- `i_step`  in  1  in step mode, executes one instruction in the cycle it is high.
- `i_pc`  in  XLEN  current PC from the PC register.
- `i_insn`  in  XLEN  instruction fetched at `i_pc`.
- `o_exec_en`  out  1  combinational. Permits PC/regfile/memory update this cycle.
- `o_done`  out  1  registered. High in DONE.
- `o_timeout`  out  1  registered. High in DONE when the stop cause was timeout.
- `o_cycle`  out  CYCLE_W  registered executed-cycle count.

## Operation
- States: IDLE, ACTIVE, DONE. The reset state is IDLE.
- IDLE: `i_start` moves the FSM to ACTIVE. `o_cycle` clears to 0 and the loop history clears.
- ACTIVE: the cycle wants to execute when `!i_step_mode || i_step`.
- `halt_now` is true when `i_insn == HALT_INSN`. With LOOP_DETECT=1, it is also true when `prev_valid && i_pc == prev_pc`.
- `tmo_now` is true when `MAX_CYCLES != 0 && o_cycle == MAX_CYCLES`.
- `o_exec_en` = ACTIVE && wants && !halt_now && !tmo_now.
- On an executing cycle: `o_cycle` increments (saturating at all-ones), `prev_pc <= i_pc`, `prev_valid <= 1`.
- On a non-executing ACTIVE cycle with no stop condition: `prev_valid` and `prev_pc` hold. This makes step gaps transparent to loop detection.
- Stop handling: if wants && halt_now, go to DONE with `o_timeout` = 0. Else if wants && tmo_now, go to DONE with `o_timeout` = 1.
- Halt has priority over timeout when both hold in the same cycle.
- The halt instruction itself is not executed or counted. The first pass of a jump-to-self is executed and counted; the second pass stops.
- DONE: `o_exec_en` = 0. `o_done`, `o_timeout` and `o_cycle` hold. `i_start` restarts the run exactly as from IDLE and clears `o_done`/`o_timeout`.
- `i_start` is ignored in ACTIVE.
- Arithmetic: the counter is CYCLE_W bits unsigned and never wraps.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `o_done` 0, `o_timeout` 0, `o_cycle` 0, `prev_valid` 0, `prev_pc` 0. `o_exec_en` is 0 because the FSM is in IDLE.
- `i_start` at edge N puts the FSM in ACTIVE after edge N. `o_exec_en` can first be high in cycle N+1.
- A stop detected in cycle K gives `o_done` = 1 after edge K+1.
- Free-run throughput is one instruction per cycle with no bubbles.
- Reset asserted mid-run aborts immediately. No partial state survives.
- A mode change takes effect the same cycle through the combinational `wants` term.

## Structure
- Shared package `proc_pkg` holds:
  - the run-state enum (IDLE/ACTIVE/DONE);
  - the EBREAK/ECALL encoding constants;
  - the default `XLEN`.
- One sub-module, `sat_counter` (parameter W; inputs clear, inc; saturating output), implements the cycle counter.
- The FSM, stop detection and loop history stay in `proc_run_ctrl`.

## Test plan
- Reset mid-ACTIVE with `o_cycle` = 5 → all registered outputs 0 immediately, FSM in IDLE.
- Free-run; PC steps 0,4,8; insn at 8 = 32'h0010_0073 → `o_exec_en` high for 2 cycles, `o_cycle` = 2, `o_done` = 1, `o_timeout` = 0.
- Free-run; insn at 4 = `jal x0,0` (PC stays 4) → `o_cycle` = 2 (insn at 0, first pass of 4), `o_done` = 1, `o_timeout` = 0.
- MAX_CYCLES = 15; straight-line code with no halt → exactly 15 executing cycles, `o_cycle` = 15, `o_timeout` = 1; same cycle holding HALT_INSN at count 15 → `o_timeout` = 0.
- Step mode; `i_step` pulsed 3 times with 2 idle cycles between → `o_cycle` = 3 and `o_exec_en` high only on pulse cycles; a repeated PC across step gaps without execution does not trigger loop halt.
- From DONE with `o_cycle` = 7, pulse `i_start` → `o_done` = 0, `o_cycle` = 0, execution resumes next cycle; `i_start` during ACTIVE → no effect on the count.
